conv1_layer1_dense_reduce: RTL

Consumer end of the conv1 layer1 dense multiplier array. It accepts the 25-lane product vector (25 x 16-bit signed Q8.8 slices) and reduces it to a dot product through a pipelined adder tree. It accumulates ACC_LEN consecutive vectors per output point, saturates the sum to 16 bits and buffers results in a small output FIFO. It drives `halt` back to the multiplier array so that no result is lost under downstream backpressure.

---
 rtl/conv1_layer1_dense_reduce.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/conv1_layer1_dense_reduce.sv
// conv1_layer1_dense_reduce
//   Reduces the 25-lane Q8.8 product vector from the conv1 layer1 dense
//   multiplier array to a dot product. It uses a pipelined adder tree with
//   three register stages (S1 group partials, S2 tree sum, S3 accumulator).
//   It accumulates ACC_LEN vectors per output point, saturates the result to
//   DW bits, and queues results in a show-ahead FIFO. It also raises `halt`
//   early enough that a queued result is never dropped under backpressure.
//
// Ports
//   clk, rst           clock (rising edge), async active-high reset
//   clr                sync flush of tree pipeline, beat counter, accumulator
//   mult_res_w         LANES x DW product vector, lane i at [DW*i +: DW]
//   mult_res_v_w       product vector valid
//   halt               registered stall request back to the multiplier array
//   dot_res            FIFO head (saturated dot product), 0 when empty
//   dot_res_v          FIFO non-empty
//   dot_res_rdy        downstream accept
//   beat_cnt           vectors accumulated into the current output point
//   ovf_err            sticky: a result arrived while the FIFO was full

// Sums one group of GL lanes, each sign-extended to SW bits.
module conv1_layer1_dense_reduce_grp #(
  parameter int DW = 16,
  parameter int SW = 21,
  parameter int GL = 5
) (
  input  logic [GL*DW-1:0] lanes,
  output logic [SW-1:0]    psum
);
  always_comb begin
    psum = '0;
    for (int i = 0; i < GL; i++)
      psum = psum + {{(SW-DW){lanes[i*DW+DW-1]}}, lanes[i*DW +: DW]};
  end
endmodule

module conv1_layer1_dense_reduce #(
  parameter int LANES   = 25,
  parameter int DW      = 16,
  parameter int ACC_W   = 32,
  parameter int ACC_LEN = 4,
  parameter int DEPTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [LANES*DW-1:0] mult_res_w,
  input  logic                mult_res_v_w,
  output logic                halt,
  output logic [DW-1:0]       dot_res,
  output logic                dot_res_v,
  input  logic                dot_res_rdy,
  output logic [7:0]          beat_cnt,
  output logic                ovf_err
);
  localparam int GL     = 5;
  localparam int NGRP   = (LANES + GL - 1) / GL;
  // Wide enough that a full-lane sum of extreme values cannot wrap.
  localparam int SW     = DW + $clog2(LANES);
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int RW     = CW + 1;
  localparam int STAGES = 3;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;
  localparam logic [7:0] LAST_CNT = 8'(ACC_LEN - 1);

  // Missing lanes in a partial last group are zero.
  logic [NGRP*GL*DW-1:0]     pad;
  logic [NGRP-1:0][SW-1:0]   part_c, s1_part;
  logic [SW-1:0]             sum_c, s2_sum;
  logic signed [ACC_W-1:0]   acc, acc_nxt;
  logic [STAGES:1]           vld_pipe, last_pipe;
  logic [7:0]                in_cnt;
  logic                      accept, last_in;

  logic [DW-1:0]             mem [DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count;
  logic [RW-1:0]             reserved;
  logic [DW-1:0]             sat_res;
  logic                      push, push_ok, pop, full;

  assign pad = (NGRP*GL*DW)'(mult_res_w);

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    conv1_layer1_dense_reduce_grp #(.DW(DW), .SW(SW), .GL(GL)) u_grp (
      .lanes (pad[g*GL*DW +: GL*DW]),
      .psum  (part_c[g])
    );
  end

  // Beats offered while halted carry frozen data and are ignored.
  assign accept  = mult_res_v_w & ~halt & ~clr;
  // The last flag is decided at the input so halt credit can count
  // results that are still travelling down the tree.
  assign last_in = (in_cnt == LAST_CNT);

  always_comb begin
    sum_c = '0;
    for (int g = 0; g < NGRP; g++) sum_c = sum_c + s1_part[g];
  end

  assign acc_nxt = ((beat_cnt == 8'd0) ? '0 : acc) +
                   {{(ACC_W-SW){s2_sum[SW-1]}}, s2_sum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      in_cnt    <= '0;
      s1_part   <= '0;
      s2_sum    <= '0;
      acc       <= '0;
      beat_cnt  <= '0;
    end else if (clr) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      in_cnt    <= '0;
      acc       <= '0;
      beat_cnt  <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], accept};
      last_pipe <= {last_pipe[STAGES-1:1], accept & last_in};
      if (accept) begin
        in_cnt  <= last_in ? 8'd0 : in_cnt + 8'd1;
        s1_part <= part_c;
      end
      if (vld_pipe[1]) s2_sum <= sum_c;
      if (vld_pipe[2]) begin
        acc      <= acc_nxt;
        beat_cnt <= (beat_cnt == LAST_CNT) ? 8'd0 : beat_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    if (acc > SAT_MAX)      sat_res = SAT_MAX[DW-1:0];
    else if (acc < SAT_MIN) sat_res = SAT_MIN[DW-1:0];
    else                    sat_res = acc[DW-1:0];
  end

  // S3 holding a completed point writes the FIFO on the following edge.
  // A flush drops the result along with the rest of the pipeline.
  assign push      = last_pipe[STAGES] & ~clr;
  assign full      = (count == CW'(DEPTH));
  assign push_ok   = push & ~full;
  assign dot_res_v = (count != '0);
  assign pop       = dot_res_v & dot_res_rdy;
  assign dot_res   = dot_res_v ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= sat_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && full) ovf_err <= 1'b1;
    end
  end

  // Credit = queued results plus completed points still in the tree.
  // The two spare entries absorb the beat that slips in during halt's
  // one-cycle lag.
  assign reserved = RW'(count) + RW'(last_pipe[1]) + RW'(last_pipe[2]) +
                    RW'(last_pipe[3]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      halt <= 1'b0;
    else if (clr) halt <= (RW'(count) >= RW'(DEPTH - 2));
    else          halt <= (reserved >= RW'(DEPTH - 2));
  end

endmodule
